// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester block-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    RESETWAIT = 2'd0,
    IDLE      = 2'd1,
    BUSY_I    = 2'd2,
    BUSY_D    = 2'd3
  } arb_state_e;

  localparam int BLOCKSIZE   = 4;
  localparam int BLOCK_W     = BLOCKSIZE * 32;
  localparam int WAIT_CYCLES = 2;

  // Byte-offset bits covered by one block (word select plus byte select).
  function automatic int block_offset_bits(input int bs);
    return $clog2(bs) + 2;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; remembers whether the last grant went to D.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic req_d,
  input  logic accept,
  output logic grant_d
);

  logic last_grant_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_d = req_d;
    if (req_i && req_d) begin
      grant_d = ~last_grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (accept && (req_i || req_d)) begin
      last_grant_d <= grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache block transfers onto one single-ported block memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int blocksize   = BLOCKSIZE,
  parameter int waitCycles  = WAIT_CYCLES,
  parameter int drainCycles = waitCycles + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    IReq,
  input  logic [31:0]             IAddr,
  output logic [blocksize*32-1:0] IRd,
  output logic                    IValid,
  input  logic                    DReq,
  input  logic                    DWrite,
  input  logic [31:0]             DAddr,
  input  logic [blocksize*32-1:0] DWd,
  output logic [blocksize*32-1:0] DRd,
  output logic                    DValid,
  output logic                    MemRE,
  output logic                    MemWE,
  output logic [31:0]             MemA,
  output logic [blocksize*32-1:0] MemWD,
  input  logic [blocksize*32-1:0] MemRD,
  input  logic                    MemValid
);

  localparam int OFFS = block_offset_bits(blocksize);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFS) - 32'd1);
  localparam int CNT_W = $clog2(drainCycles + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drainCycles - 1);

  arb_state_e       state;
  logic [CNT_W-1:0] drain_cnt;
  logic             grant_d;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_i  (IReq),
    .req_d  (DReq),
    .accept (state == IDLE),
    .grant_d(grant_d)
  );

  // The memory has no reset, so after reset we wait long enough for any
  // in-flight access to finish before driving the port again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESETWAIT;
      drain_cnt <= '0;
      MemRE     <= 1'b0;
      MemWE     <= 1'b0;
      MemA      <= '0;
      MemWD     <= '0;
    end else begin
      case (state)
        RESETWAIT: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (IReq || DReq) begin
            if (grant_d) begin
              MemA  <= DAddr & ADDR_MASK;
              MemWD <= DWd;
              MemWE <= DWrite;
              MemRE <= ~DWrite;
              state <= BUSY_D;
            end else begin
              MemA  <= IAddr & ADDR_MASK;
              MemWE <= 1'b0;
              MemRE <= 1'b1;
              state <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // Dropping the enables here keeps the memory from re-triggering.
          if (MemValid) begin
            MemRE <= 1'b0;
            MemWE <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= RESETWAIT;
      endcase
    end
  end

  assign IValid = !reset && (state == BUSY_I) && MemValid;
  assign DValid = !reset && (state == BUSY_D) && MemValid;
  assign IRd    = (state == BUSY_I) ? MemRD : '0;
  assign DRd    = (state == BUSY_D) ? MemRD : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural block memory (no reset, fixed wait).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int BS     = 4;
  localparam int BW     = BS * 32;
  localparam int WAITC  = 2;
  localparam int DRAIN  = WAITC + 3;
  localparam int BUDGET = 60;
  localparam logic [BW-1:0] BEEF = {4{32'hDEADBEEF}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          IReq = 1'b0;
  logic [31:0]   IAddr = '0;
  logic [BW-1:0] IRd;
  logic          IValid;
  logic          DReq = 1'b0;
  logic          DWrite = 1'b0;
  logic [31:0]   DAddr = '0;
  logic [BW-1:0] DWd = '0;
  logic [BW-1:0] DRd;
  logic          DValid;
  logic          MemRE;
  logic          MemWE;
  logic [31:0]   MemA;
  logic [BW-1:0] MemWD;
  logic [BW-1:0] MemRD = '0;
  logic          MemValid = 1'b0;

  int tests_run = 0;
  int fail_count = 0;

  typedef struct {
    bit            is_d;
    bit            chk;
    logic [BW-1:0] data;
    string         name;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  mem_arbiter #(.blocksize(BS), .waitCycles(WAITC), .drainCycles(DRAIN)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRd(IRd), .IValid(IValid),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWd(DWd), .DRd(DRd), .DValid(DValid),
    .MemRE(MemRE), .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD),
    .MemRD(MemRD), .MemValid(MemValid)
  );

  task automatic fail_now(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    fail_count++;
    $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
  endtask

  task automatic check_output(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests_run++;
    if (act !== exp) fail_now(name, act, exp);
  endtask

  task automatic push_exp(input bit is_d, input bit chk, input logic [BW-1:0] data, input string name);
    exp_t e;
    e.is_d = is_d; e.chk = chk; e.data = data; e.name = name;
    expq.push_back(e);
  endtask

  // Behavioural memory: samples the port at negedge, acts at posedge, has no reset.
  initial begin : mem_model
    logic [31:0]   mem [0:255];
    logic          s_re, s_we;
    logic [31:0]   s_a, maddr;
    logic [BW-1:0] s_wd, mwd, blk;
    logic          mwrite;
    int            mcnt, mstate;
    bit            just_idle;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | (i * 4);
    mstate = 0; mcnt = 0; just_idle = 0; mwrite = 0; maddr = '0; mwd = '0; blk = '0;
    forever begin
      @(negedge clk);
      s_re = MemRE; s_we = MemWE; s_a = MemA; s_wd = MemWD;
      @(posedge clk);
      case (mstate)
        0: begin
          if (just_idle && (s_re || s_we)) fail_now("mem_retrigger", BW'({s_re, s_we}), '0);
          just_idle = 0;
          if (s_re || s_we) begin
            maddr = s_a; mwrite = s_we; mwd = s_wd; mcnt = WAITC; mstate = 1;
          end
        end
        1: begin
          if (mcnt > 0) mcnt--;
          else begin
            for (int k = 0; k < BS; k++) begin
              if (mwrite) mem[8'(maddr[9:2] + 8'(k))] = mwd[k*32 +: 32];
              blk[k*32 +: 32] = mem[8'(maddr[9:2] + 8'(k))];
            end
            MemRD <= blk;
            MemValid <= 1'b1;
            mstate = 2;
          end
        end
        default: begin
          MemValid <= 1'b0;
          mstate = 0;
          just_idle = 1;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every Valid and watches port stability.
  initial begin : monitor
    logic          p_busy, p_valid, p_reset, have_prev;
    logic [BW+33:0] p_port;
    exp_t          e;
    logic [BW-1:0] act;
    have_prev = 0; p_busy = 0; p_valid = 0; p_reset = 0; p_port = '0;
    forever begin
      @(negedge clk);
      if (IValid && DValid) fail_now("both_valid", BW'({IValid, DValid}), BW'(0));
      if (IValid || DValid) begin
        tests_run++;
        act = DValid ? DRd : IRd;
        if (expq.size() == 0) fail_now("unexpected_valid", BW'({IValid, DValid}), BW'(0));
        else begin
          e = expq.pop_front();
          if (e.is_d != DValid) fail_now({e.name, "_route"}, BW'({IValid, DValid}), BW'({!e.is_d, e.is_d}));
          else if (e.chk && act !== e.data) fail_now(e.name, act, e.data);
        end
      end
      if (have_prev && p_busy && !p_valid && !p_reset && {MemRE, MemWE, MemA, MemWD} !== p_port)
        fail_now("mem_stable", BW'(MemA), BW'(p_port[BW +: 32]));
      have_prev = 1;
      p_busy = MemRE || MemWE; p_valid = MemValid; p_reset = reset;
      p_port = {MemRE, MemWE, MemA, MemWD};
    end
  end

  task automatic wait_valid(input bit is_d);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      if (is_d ? DValid : IValid) seen = 1;
      n++;
    end
    if (!seen) begin
      tests_run++;
      fail_now(is_d ? "timeout_dvalid" : "timeout_ivalid", BW'(n), BW'(BUDGET));
    end
  endtask

  task automatic drive_i(input logic [31:0] addr);
    IReq = 1'b1; IAddr = addr;
    wait_valid(1'b0);
    @(posedge clk); #1;
    IReq = 1'b0;
  endtask

  task automatic drive_d(input logic wr, input logic [31:0] addr, input logic [BW-1:0] wd);
    DReq = 1'b1; DWrite = wr; DAddr = addr; DWd = wd;
    wait_valid(1'b1);
    @(posedge clk); #1;
    DReq = 1'b0; DWrite = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : apply_stimulus
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_memre", BW'(MemRE), '0);
    check_output("rst_memwe", BW'(MemWE), '0);
    check_output("rst_mema", BW'(MemA), '0);
    check_output("rst_memwd", MemWD, '0);
    check_output("rst_ivalid", BW'(IValid), '0);
    check_output("rst_dvalid", BW'(DValid), '0);

    // Request straight out of reset; the grant must wait out the drain window.
    push_exp(0, 1, 128'hA000001C_A0000018_A0000014_A0000010, "i_read_14");
    @(posedge clk); #1;
    reset = 1'b0; IReq = 1'b1; IAddr = 32'h0000_0014;
    n = 0;
    while (!MemRE && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain_latency", BW'(n), BW'(DRAIN + 1));
    check_output("i_mema", BW'(MemA), BW'(32'h10));
    check_output("i_memwe", BW'(MemWE), '0);
    drive_i(32'h0000_0014);

    // First tie after reset goes to D.
    push_exp(1, 1, 128'hA000008C_A0000088_A0000084_A0000080, "tie1_d");
    push_exp(0, 1, 128'hA000002C_A0000028_A0000024_A0000020, "tie1_i");
    fork
      drive_d(1'b0, 32'h0000_0080, '0);
      drive_i(32'h0000_0020);
    join

    push_exp(1, 0, '0, "d_write_40");
    drive_d(1'b1, 32'h0000_0040, BEEF);
    push_exp(1, 1, BEEF, "d_read_40");
    drive_d(1'b0, 32'h0000_0048, '0);

    // Last grant was D, so this tie goes to I.
    push_exp(0, 1, 128'hA000003C_A0000038_A0000034_A0000030, "tie2_i");
    push_exp(1, 1, BEEF, "tie2_d");
    fork
      drive_i(32'h0000_0030);
      drive_d(1'b0, 32'h0000_0040, '0);
    join

    // Reset during BUSY_D: no DValid, stray MemValid ignored.
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h0000_0080;
    n = 0;
    while (!MemRE && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("rst_busy_grant", BW'(MemRE), BW'(1));
    @(posedge clk); #1;
    reset = 1'b1; DReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_busy_re", BW'(MemRE), '0);
    check_output("rst_busy_we", BW'(MemWE), '0);
    @(posedge clk); #1;
    push_exp(0, 1, 128'hA000002C_A0000028_A0000024_A0000020, "i_after_rst");
    drive_i(32'h0000_0024);

    // D held high across three back-to-back reads.
    push_exp(1, 1, 128'hA000000C_A0000008_A0000004_A0000000, "b2b_0");
    push_exp(1, 1, 128'hA000001C_A0000018_A0000014_A0000010, "b2b_1");
    push_exp(1, 1, 128'hA000002C_A0000028_A0000024_A0000020, "b2b_2");
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b1);
      @(posedge clk); #1;
      if (k < 2) DAddr = 32'(k + 1) << 4;
      else DReq = 1'b0;
      @(negedge clk);
      check_output("b2b_gap_re", BW'({MemRE, MemWE}), '0);
    end

    repeat (10) @(posedge clk);
    check_output("queue_empty", BW'(expq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
